// File: rtl/iref_seq.sv
`default_nettype none
// ============================================================================
//  Module   : iref_seq
//  Purpose  : Power-up sequencer for the IREF current reference. Turns a
//             level enable into the ordered iref_pd / iref_charge sequence,
//             then flags the reference as ready after a settle interval.
//  Revision : 1.0  initial release
// ============================================================================
module iref_seq #(
  parameter int CHARGE_CYCLES = 16,
  parameter int SETTLE_CYCLES = 32,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic recal,
  output logic iref_pd,
  output logic iref_charge,
  output logic ready,
  output logic busy
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_CHARGE = 2'd1,
    ST_SETTLE = 2'd2,
    ST_ON     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CHARGE_LAST = CNT_W'(CHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_pd;
  logic             w_charge;
  logic             w_ready;
  logic             w_busy;

  // Next-state and counter: en low wins over everything, terminal counts
  // take precedence over a recal pulse arriving on the same edge.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    if (!en) begin
      w_next_state = ST_OFF;
      w_next_cnt   = C_CNT_ZERO;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_next_state = ST_CHARGE;
          w_next_cnt   = C_CNT_ZERO;
        end
        ST_CHARGE: begin
          if (r_cnt == C_CHARGE_LAST) begin
            w_next_state = ST_SETTLE;
            w_next_cnt   = C_CNT_ZERO;
          end else if (recal) begin
            w_next_cnt   = C_CNT_ZERO;
          end else begin
            w_next_cnt   = r_cnt + C_CNT_ONE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == C_SETTLE_LAST) begin
            w_next_state = ST_ON;
            w_next_cnt   = C_CNT_ZERO;
          end else if (recal) begin
            w_next_state = ST_CHARGE;
            w_next_cnt   = C_CNT_ZERO;
          end else begin
            w_next_cnt   = r_cnt + C_CNT_ONE;
          end
        end
        ST_ON: begin
          if (recal) begin
            w_next_state = ST_CHARGE;
            w_next_cnt   = C_CNT_ZERO;
          end
        end
        default: begin
          w_next_state = ST_OFF;
          w_next_cnt   = C_CNT_ZERO;
        end
      endcase
    end
  end

  // Output decode of the upcoming state, so the analog pins come straight
  // from flops and never glitch.
  always_comb begin
    w_pd     = 1'b1;
    w_charge = 1'b1;
    w_ready  = 1'b0;
    w_busy   = 1'b0;
    case (w_next_state)
      ST_CHARGE: begin
        w_pd     = 1'b0;
        w_charge = 1'b1;
        w_busy   = 1'b1;
      end
      ST_SETTLE: begin
        w_pd     = 1'b0;
        w_charge = 1'b0;
        w_busy   = 1'b1;
      end
      ST_ON: begin
        w_pd     = 1'b0;
        w_charge = 1'b0;
        w_ready  = 1'b1;
      end
      default: begin
        w_pd     = 1'b1;
        w_charge = 1'b1;
      end
    endcase
  end

  // State, counter and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_OFF;
      r_cnt       <= C_CNT_ZERO;
      iref_pd     <= 1'b1;
      iref_charge <= 1'b1;
      ready       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      iref_pd     <= w_pd;
      iref_charge <= w_charge;
      ready       <= w_ready;
      busy        <= w_busy;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iref_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iref_seq
//  Purpose  : Self-checking bench for iref_seq; nominal (16/32) and minimal
//             (1/1) instances driven from the same inputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iref_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic recal;

  logic a_pd, a_chg, a_rdy, a_busy;
  logic b_pd, b_chg, b_rdy, b_busy;

  int checks = 0;
  int errors = 0;

  // Reference model: sequence position t counted from CHARGE entry.
  bit on_m [2];
  int t_m  [2];
  int cc   [2] = '{16, 1};
  int ss   [2] = '{32, 1};

  iref_seq #(.CHARGE_CYCLES(16), .SETTLE_CYCLES(32), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .recal(recal),
    .iref_pd(a_pd), .iref_charge(a_chg), .ready(a_rdy), .busy(a_busy)
  );

  iref_seq #(.CHARGE_CYCLES(1), .SETTLE_CYCLES(1), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .recal(recal),
    .iref_pd(b_pd), .iref_charge(b_chg), .ready(b_rdy), .busy(b_busy)
  );

  always #5 clk = ~clk;

  // Forbidden pin combination: powered down while not charging.
  always @(negedge clk) begin
    assert (!(a_pd && !a_chg) && !(b_pd && !b_chg)) else begin
      errors++;
      $error("FAIL pd_chg_invariant a=%b%b b=%b%b", a_pd, a_chg, b_pd, b_chg);
    end
  end

  function automatic logic [3:0] exp_out(int idx);
    // {iref_pd, iref_charge, ready, busy}
    if (!on_m[idx])                        return 4'b1100;
    else if (t_m[idx] < cc[idx])           return 4'b0101;
    else if (t_m[idx] < cc[idx] + ss[idx]) return 4'b0001;
    else                                   return 4'b0010;
  endfunction

  task automatic model_edge(int idx);
    int last_c = cc[idx] - 1;
    int last_s = cc[idx] + ss[idx] - 1;
    int full   = cc[idx] + ss[idx];
    if (!rst_n || !en) begin
      on_m[idx] = 0;
      t_m[idx]  = 0;
    end else if (!on_m[idx]) begin
      on_m[idx] = 1;
      t_m[idx]  = 0;
    end else if (t_m[idx] >= full) begin
      if (recal) t_m[idx] = 0;
    end else if (t_m[idx] == last_c || t_m[idx] == last_s) begin
      t_m[idx] = t_m[idx] + 1;
    end else if (recal) begin
      t_m[idx] = 0;
    end else begin
      t_m[idx] = t_m[idx] + 1;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model on the edge, then compare both instances.
  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check("model_a", {28'd0, a_pd, a_chg, a_rdy, a_busy}, {28'd0, exp_out(0)});
    check("model_b", {28'd0, b_pd, b_chg, b_rdy, b_busy}, {28'd0, exp_out(1)});
  endtask

  int a_busy_n, a_chg_n, a_rdy_at, b_busy_n, b_chg_n, b_rdy_at;
  int k;
  int rdy_low_n, chg_hi_n;

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    recal = 1'b0;

    // Reset held with en high: outputs stay at OFF values.
    repeat (3) begin
      step();
      check("reset_a", {28'd0, a_pd, a_chg, a_rdy, a_busy}, 32'h0000000C);
    end
    rst_n = 1'b1;
    en    = 1'b0;
    repeat (2) step();

    // Nominal power-up, edge E0 is the first step with en high.
    en = 1'b1;
    a_busy_n = 0; a_chg_n = 0; a_rdy_at = -1;
    b_busy_n = 0; b_chg_n = 0; b_rdy_at = -1;
    for (int i = 0; i < 56; i++) begin
      step();
      if (i == 0) check("pd_fall_after_e0", {31'd0, a_pd}, 32'd0);
      a_busy_n += int'(a_busy);
      a_chg_n  += int'(a_chg && !a_pd);
      b_busy_n += int'(b_busy);
      b_chg_n  += int'(b_chg && !b_pd);
      if (a_rdy && a_rdy_at < 0) a_rdy_at = i;
      if (b_rdy && b_rdy_at < 0) b_rdy_at = i;
    end
    check("nom_busy_cycles",   a_busy_n, 48);
    check("nom_charge_cycles", a_chg_n,  16);
    check("nom_ready_edge",    a_rdy_at, 48);
    check("bnd_busy_cycles",   b_busy_n, 2);
    check("bnd_charge_cycles", b_chg_n,  1);
    check("bnd_ready_edge",    b_rdy_at, 2);

    // Abort during CHARGE at E0+10, then restart.
    en = 1'b0;
    step();
    en = 1'b1;
    repeat (10) step();
    en = 1'b0;
    step();
    check("abort_off_a", {28'd0, a_pd, a_chg, a_rdy, a_busy}, 32'h0000000C);
    en = 1'b1;
    step();
    k = 0;
    while (a_chg && k < 40) begin
      step();
      k++;
    end
    check("restart_charge_len", k, 16);

    // Reach ON (bounded), then recalibrate.
    k = 0;
    while (!a_rdy && k < 100) begin
      step();
      k++;
    end
    check("reach_on", {31'd0, a_rdy}, 32'd1);
    recal = 1'b1;
    step();
    recal = 1'b0;
    check("recal_ready_drop", {30'd0, a_rdy, a_chg}, 32'd1);
    rdy_low_n = 0;
    chg_hi_n  = 0;
    while (!a_rdy && rdy_low_n < 100) begin
      rdy_low_n++;
      chg_hi_n += int'(a_chg);
      step();
    end
    check("recal_ready_low", rdy_low_n, 48);
    check("recal_charge_hi", chg_hi_n,  16);

    // recal and en=0 on the same edge in ON: straight to OFF.
    en    = 1'b0;
    recal = 1'b1;
    step();
    recal = 1'b0;
    check("simul_off_a", {28'd0, a_pd, a_chg, a_rdy, a_busy}, 32'h0000000C);
    check("simul_off_b", {28'd0, b_pd, b_chg, b_rdy, b_busy}, 32'h0000000C);
    en = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      en    = ($urandom_range(0, 39) != 0);
      recal = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iref_seq.md
# iref_seq

Power-up sequencer that drives the control pins of the current reference generator (IREF) in the WSN analog front end. It turns a single digital enable into the ordered `iref_pd`/`iref_charge` sequence. `iref_pd` is released first, and `iref_charge` is held high for a programmed number of cycles before being dropped. After a further settle interval the block flags the reference as ready. It sits between the SoC control register bank (upstream) and the IREF model/macro (downstream).

## Interface
- `CHARGE_CYCLES`, 16: cycles `iref_charge` stays high after `iref_pd` falls; legal range ≥1.
- `SETTLE_CYCLES`, 32: cycles after `iref_charge` falls before `ready` asserts; legal range ≥1.
- `CNT_W`, 8: counter width; must hold max(CHARGE_CYCLES, SETTLE_CYCLES)-1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `en`  in  1  level request: 1 = reference on, 0 = power down.
- `recal`  in  1  single-cycle pulse; restarts the charge phase while on.
- `iref_pd`  out  1  to IREF power-down pin (1 = powered down).
- `iref_charge`  out  1  to IREF fast-charge pin (1 = charging/default).
- `ready`  out  1  reference current valid.
- `busy`  out  1  high in CHARGE or SETTLE.

## Operation
- Four-state FSM. Every output is a registered function of state.
  - OFF: `iref_pd`=1, `iref_charge`=1, `ready`=0, `busy`=0.
  - CHARGE: `iref_pd`=0, `iref_charge`=1, `busy`=1.
  - SETTLE: `iref_pd`=0, `iref_charge`=0, `busy`=1.
  - ON: `iref_pd`=0, `iref_charge`=0, `ready`=1.
- Transitions, evaluated at each rising edge in priority order:
  1. `en`=0 in any state → OFF and counter cleared. This overrides `recal`.
  2. OFF with `en`=1 → CHARGE, counter=0.
  3. CHARGE when counter reaches CHARGE_CYCLES-1 → SETTLE, counter=0. Otherwise the counter increments.
  4. SETTLE when counter reaches SETTLE_CYCLES-1 → ON, counter=0. Otherwise the counter increments.
  5. ON with `recal`=1 → CHARGE, counter=0. `ready` drops in the same cycle `iref_charge` rises.
  6. `recal` in CHARGE or SETTLE → restart CHARGE with counter=0.
- `iref_pd`=0 with `iref_charge`=1 occurs only in CHARGE. The block never produces `iref_pd`=1 with `iref_charge`=0.
- Counter: unsigned, CNT_W bits, never wraps. Reaching the terminal count forces a state change.

## Timing
- Reset (`rst_n`=0 at an edge): state OFF, counter 0. Outputs after that edge: `iref_pd`=1, `iref_charge`=1, `ready`=0, `busy`=0. Reset mid-sequence behaves identically.
- `en` first sampled 1 at edge E0 → `iref_pd` falls after E0.
- `iref_charge` falls after edge E0+CHARGE_CYCLES. It is high with `iref_pd` low for exactly CHARGE_CYCLES cycles.
- `ready` rises after edge E0+CHARGE_CYCLES+SETTLE_CYCLES.
- `en` sampled 0 at edge Ex → all outputs return to OFF values after Ex, one cycle of latency. This applies in every state.
- `en` re-asserted the cycle after dropping → full sequence restarts from CHARGE with counts fresh.
- `recal` sampled in ON at Er → `ready`=0 and `iref_charge`=1 after Er. `ready` returns after Er+CHARGE_CYCLES+SETTLE_CYCLES.
- `en` and `recal` are synchronous to `clk`. Their synchronizers are external to this block.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `en`=1 → `iref_pd`=1, `iref_charge`=1, `ready`=0, `busy`=0 throughout.
- Nominal power-up (CHARGE_CYCLES=16, SETTLE_CYCLES=32), `en` rises at E0:
  - `iref_pd` falls after E0.
  - `iref_charge` falls after E0+16.
  - `ready` rises after E0+48.
  - `busy` is high for exactly 48 cycles.
- Abort: drop `en` at E0+10, during CHARGE → next cycle all outputs at OFF values. Re-assert `en` → `iref_charge` falls exactly 16 cycles after the new sampling edge.
- Recalibrate: pulse `recal` one cycle in ON → `ready` low for 48 cycles, `iref_charge` high for exactly 16 of them.
- Simultaneous: `recal`=1 and `en`=0 at the same edge in ON → OFF, with no CHARGE entry.
- Boundary (CHARGE_CYCLES=1, SETTLE_CYCLES=1): `iref_charge` is high with `iref_pd` low for 1 cycle, and `ready` rises after E0+2. An assertion checks `iref_pd`=1 ∧ `iref_charge`=0 never occurs.
